// File: rtl/if_fetch_unit_pkg.sv
// Shared fetch/decode definitions: fetch FSM encoding, default constants,
// the {pc, instr} pair type and primary opcodes used by decode.
package if_fetch_unit_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_FULL = 2'd2
  } state_t;

  localparam logic [31:0] DEF_PC_STEP   = 32'd4;
  localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_0000;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_JAL   = 6'd3;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_pair_t;

endpackage

// File: rtl/if_fetch_unit_hold.sv
// One-entry skid register that parks a returned {pc, instr} while decode stalls.
module if_hold_buffer
  import if_fetch_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        clear,
  input  fetch_pair_t din,
  output fetch_pair_t dout,
  output logic        full
);

  // clear wins so a redirect can never leave stale data parked
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      full <= 1'b0;
      dout <= '0;
    end else if (load) begin
      full <= 1'b1;
      dout <= din;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: owns the PC, keeps one imem read outstanding and
// presents a registered {fetch_pc, instr, instr_valid} to decode.
//
// Handshakes: a request transfers on a cycle where imem_req & imem_ready are
// both high; imem_req depends only on state, never on imem_ready. A response
// transfers on any cycle where imem_rvalid is high while in S_WAIT; there is
// no back-pressure on responses. Decode consumes the output pair on every edge
// where stall_i is low.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] PC_STEP   = DEF_PC_STEP,
  parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  input  logic        jump_i,
  input  logic [31:0] jump_addr_i,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] fetch_pc,
  output logic [31:0] instr,
  output logic        instr_valid,
  output state_t      dbg_state
);

  state_t      state;
  logic [31:0] pc;
  logic [31:0] req_pc;
  logic        drop;

  logic        redirect;
  logic [31:0] target;
  logic        wait_accept;
  logic        full_unload;
  logic        buf_load;
  logic        buf_clear;
  logic        buf_full;
  fetch_pair_t buf_q;
  fetch_pair_t buf_d;

  assign redirect  = branch_taken_i | jump_i;
  assign target    = branch_taken_i ? branch_target_i : jump_addr_i;
  assign imem_req  = (state == S_REQ);
  assign imem_addr = pc;
  assign dbg_state = state;

  // a response is kept only if nothing invalidated it while in flight
  assign wait_accept = (state == S_WAIT) & imem_rvalid & ~drop & ~redirect;
  assign full_unload = (state == S_FULL) & buf_full & ~redirect & ~stall_i;
  assign buf_load    = wait_accept & stall_i;
  assign buf_clear   = redirect | full_unload;
  assign buf_d       = '{pc: req_pc, instr: imem_rdata};

  if_hold_buffer u_hold (
    .clk   (clk),
    .rst   (rst),
    .load  (buf_load),
    .clear (buf_clear),
    .din   (buf_d),
    .dout  (buf_q),
    .full  (buf_full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_REQ;
      pc          <= RESET_PC;
      req_pc      <= '0;
      drop        <= 1'b0;
      fetch_pc    <= '0;
      instr       <= NOP_INSTR;
      instr_valid <= 1'b0;
    end else begin
      // decode-facing registers; fetch_pc is left alone on bubbles
      if (redirect) begin
        instr       <= NOP_INSTR;
        instr_valid <= 1'b0;
      end else if (wait_accept && !stall_i) begin
        fetch_pc    <= req_pc;
        instr       <= imem_rdata;
        instr_valid <= 1'b1;
      end else if (full_unload) begin
        fetch_pc    <= buf_q.pc;
        instr       <= buf_q.instr;
        instr_valid <= 1'b1;
      end else if (!stall_i) begin
        instr       <= NOP_INSTR;
        instr_valid <= 1'b0;
      end

      if (redirect) begin
        pc <= target;
      end

      case (state)
        S_REQ: begin
          if (imem_ready) begin
            req_pc <= pc;
            state  <= S_WAIT;
            if (redirect) begin
              drop <= 1'b1;
            end else begin
              pc <= pc + PC_STEP;
            end
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            drop  <= 1'b0;
            state <= (drop || redirect || !stall_i) ? S_REQ : S_FULL;
          end else if (redirect) begin
            drop <= 1'b1;
          end
        end
        S_FULL: begin
          if (redirect || !stall_i) begin
            state <= S_REQ;
          end
        end
        default: state <= S_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: memory/decode driver with a transaction-level
// reference, an expected-pair queue and a negedge monitor that consumes it.
module tb_if_fetch_unit;
  import if_fetch_unit_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_i = 1'b0;
  logic        branch_taken_i = 1'b0;
  logic [31:0] branch_target_i = '0;
  logic        jump_i = 1'b0;
  logic [31:0] jump_addr_i = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] fetch_pc;
  logic [31:0] instr;
  logic        instr_valid;
  state_t      dbg_state;

  if_fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk             (clk),
    .rst             (rst),
    .stall_i         (stall_i),
    .branch_taken_i  (branch_taken_i),
    .branch_target_i (branch_target_i),
    .jump_i          (jump_i),
    .jump_addr_i     (jump_addr_i),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ready      (imem_ready),
    .imem_rvalid     (imem_rvalid),
    .imem_rdata      (imem_rdata),
    .fetch_pc        (fetch_pc),
    .instr           (instr),
    .instr_valid     (instr_valid),
    .dbg_state       (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int pops  = 0;

  // reference: program-order PC, one outstanding read, pairs owed to decode
  logic [63:0] exp_q[$];
  logic [31:0] exp_pc = RST_PC;
  logic        infl = 1'b0;
  logic        dead = 1'b0;
  logic [31:0] infl_addr = '0;
  int          infl_cnt = 0;
  int          mem_lat_max = 0;
  logic [63:0] mon_e;
  logic [31:0] a_pc;
  logic [31:0] b_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // one cycle of memory + decode + execute behaviour
  task automatic step(input logic st, input logic br, input logic [31:0] bt,
                      input logic jp, input logic [31:0] ja, input logic rdy);
    logic        rv;
    logic        acc;
    logic        redir;
    logic [31:0] tgt;
    @(posedge clk);
    #1;
    redir = br | jp;
    tgt   = br ? bt : ja;
    rv    = 1'b0;
    if (infl) begin
      if (infl_cnt == 0) rv = 1'b1;
      else infl_cnt--;
    end
    if (imem_req) begin
      check32("imem_addr", imem_addr, exp_pc);
      if (infl) begin
        total++;
        bad++;
        $display("FAIL one_outstanding: got imem_req=1 expected 0 at %0t", $time);
      end
    end
    acc             = imem_req & rdy;
    stall_i         = st;
    branch_taken_i  = br;
    branch_target_i = bt;
    jump_i          = jp;
    jump_addr_i     = ja;
    imem_ready      = rdy;
    imem_rvalid     = rv;
    imem_rdata      = rv ? mem_word(infl_addr) : $urandom;
    if (rv) begin
      if (!dead && !redir) exp_q.push_back({infl_addr, mem_word(infl_addr)});
      infl = 1'b0;
    end
    if (infl && redir) dead = 1'b1;
    if (acc) begin
      infl      = 1'b1;
      infl_addr = exp_pc;
      infl_cnt  = $urandom_range(0, mem_lat_max);
      dead      = redir;
    end
    if (acc) exp_pc = redir ? tgt : exp_pc + DEF_PC_STEP;
    else if (redir) exp_pc = tgt;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    stall_i = 1'b0; branch_taken_i = 1'b0; jump_i = 1'b0;
    imem_ready = 1'b0; imem_rvalid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    infl   = 1'b0;
    dead   = 1'b0;
    exp_pc = RST_PC;
    check32("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
    check32("rst_instr", instr, DEF_NOP_INSTR);
    check32("rst_fetch_pc", fetch_pc, 32'd0);
    check32("rst_imem_req", {31'b0, imem_req}, 32'd1);
    check32("rst_imem_addr", imem_addr, RST_PC);
    check32("rst_state", 32'(dbg_state), 32'(S_REQ));
  endtask

  // monitor: decode consumes the pair on each edge where stall_i is low
  always @(negedge clk) begin
    if (!rst) begin
      if (!instr_valid) check32("bubble_instr", instr, DEF_NOP_INSTR);
      if (instr_valid && !stall_i) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_instr: got pc %h instr %h expected none at %0t",
                   fetch_pc, instr, $time);
        end else begin
          mon_e = exp_q.pop_front();
          check32("fetch_pc", fetch_pc, mon_e[63:32]);
          check32("instr", instr, mon_e[31:0]);
          pops++;
        end
      end
      if (branch_taken_i || jump_i) exp_q.delete();
    end
  end

  initial begin
    do_reset();

    // back-to-back sequential fetch, minimum latency
    mem_lat_max = 0;
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
    idle(3);
    check32("seq_delivered", 32'(pops >= 3), 32'd1);

    // stall with a response parked in the hold buffer
    a_pc = exp_pc;
    step(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
    step(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
    b_pc = exp_pc;
    step(1'b1, 1'b0, '0, 1'b0, '0, 1'b1);
    check32("stall_a_valid", {31'b0, instr_valid}, 32'd1);
    check32("stall_a_pc", fetch_pc, a_pc);
    step(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
      check32("full_state", 32'(dbg_state), 32'(S_FULL));
      check32("full_no_req", {31'b0, imem_req}, 32'd0);
      check32("full_hold_pc", fetch_pc, a_pc);
    end
    step(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
    check32("unload_valid", {31'b0, instr_valid}, 32'd1);
    check32("unload_pc", fetch_pc, b_pc);
    check32("unload_req", {31'b0, imem_req}, 32'd1);

    // jump while waiting for the response
    idle(3);
    step(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
    step(1'b0, 1'b0, '0, 1'b1, 32'h100, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
    check32("jump_addr", imem_addr, 32'h100);
    check32("jump_bubble", {31'b0, instr_valid}, 32'd0);

    // branch beats jump
    step(1'b0, 1'b1, 32'h40, 1'b1, 32'h80, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
    check32("branch_prio", imem_addr, 32'h40);

    // redirect in the same cycle as the handshake
    step(1'b0, 1'b0, '0, 1'b1, 32'h10, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1, 32'h200, 1'b1);
    step(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
    check32("same_cycle_addr", imem_addr, 32'h200);
    check32("same_cycle_drop", {31'b0, instr_valid}, 32'd0);

    // reset while parked in S_FULL, then PC wrap
    idle(3);
    step(1'b1, 1'b0, '0, 1'b0, '0, 1'b1);
    step(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
    check32("pre_rst_full", 32'(dbg_state), 32'(S_FULL));
    do_reset();
    step(1'b0, 1'b0, '0, 1'b1, 32'hFFFF_FFFC, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
    step(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
    check32("wrap_addr", imem_addr, 32'h0);
    check32("wrap_valid", {31'b0, instr_valid}, 32'd1);
    check32("wrap_pc", fetch_pc, 32'hFFFF_FFFC);

    // randomized traffic
    mem_lat_max = 3;
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 99) < 30,
           $urandom_range(0, 99) < 4, $urandom & 32'hFFFF_FFFC,
           $urandom_range(0, 99) < 4, $urandom & 32'hFFFF_FFFC,
           $urandom_range(0, 99) < 70);
    end
    idle(12);
    check32("drain_empty", 32'(exp_q.size()), 32'd0);
    check32("rand_delivered", 32'(pops >= 100), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
